// File: rtl/vec_share_pkg.sv
// Shared types and helpers for the vector-sharing arbiter and its round-robin picker.
package vec_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_V1_W = 2;
    localparam int DEF_V2_W = 6;

    // Minimum 1 so single-entry counters/pointers still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module vec_rr_pick
    import vec_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [0:NUM_REQ-1] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [0:NUM_REQ-1] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end
        end
    end

endmodule

// File: rtl/vec_share_arbiter.sv
// Round-robin arbiter sharing one vector1/vector2 consumer between NUM_REQ requesters,
// with a valid/ready handoff and a programmable hold time before re-arbitration.
module vec_share_arbiter
    import vec_share_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int V1_W        = DEF_V1_W,
    parameter int V2_W        = DEF_V2_W,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:NUM_REQ-1]       req,
    input  logic [0:NUM_REQ*V1_W-1]  req_vector1,
    input  logic [0:NUM_REQ*V2_W-1]  req_vector2,
    output logic [0:NUM_REQ-1]       gnt,
    output logic [0:V1_W-1]          vector1,
    output logic [0:V2_W-1]          vector2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t             r_state;
    logic [0:NUM_REQ-1] r_gnt;
    logic [0:V1_W-1]    r_vec1;
    logic [0:V2_W-1]    r_vec2;
    logic               r_valid;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [0:NUM_REQ-1] w_onehot;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic [0:V1_W-1]    w_win_v1;
    logic [0:V2_W-1]    w_win_v2;

    vec_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // Ascending slices copied left-to-left, so index 0 stays the MSB end-to-end.
    always_comb begin
        w_win_v1 = '0;
        w_win_v2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_win_v1 = req_vector1[i*V1_W +: V1_W];
                w_win_v2 = req_vector2[i*V2_W +: V2_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_vec1  <= '0;
            r_vec2  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_vec1  <= w_win_v1;
                        r_vec2  <= w_win_v2;
                        r_valid <= 1'b1;
                        r_ptr   <= (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_gnt <= '0;
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (HOLD_CYCLES > 0) begin
                            r_state <= HOLD;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign vector1   = r_vec1;
    assign vector2   = r_vec2;
    assign out_valid = r_valid;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_vec_share_arbiter.sv
// Scoreboard bench for vec_share_arbiter: a HOLD_CYCLES=3 instance for most scenarios
// and a HOLD_CYCLES=0 instance for back-to-back round-robin order and throughput.
module tb_vec_share_arbiter;

    localparam int N  = 4;
    localparam int V1 = 2;
    localparam int V2 = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [0:N-1]     req, req_h0;
    logic [0:N*V1-1]  rv1;
    logic [0:N*V2-1]  rv2;
    logic             out_ready;

    logic [0:N-1]     gnt, gnt_h0;
    logic [0:V1-1]    vector1, vector1_h0;
    logic [0:V2-1]    vector2, vector2_h0;
    logic             out_valid, out_valid_h0;
    logic             busy, busy_h0;

    always #5 clk = ~clk;

    vec_share_arbiter #(.NUM_REQ(N), .V1_W(V1), .V2_W(V2), .HOLD_CYCLES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_vector1(rv1), .req_vector2(rv2),
        .gnt(gnt), .vector1(vector1), .vector2(vector2), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    vec_share_arbiter #(.NUM_REQ(N), .V1_W(V1), .V2_W(V2), .HOLD_CYCLES(0)) u_dut_h0 (
        .clk(clk), .rst_n(rst_n), .req(req_h0), .req_vector1(rv1), .req_vector2(rv2),
        .gnt(gnt_h0), .vector1(vector1_h0), .vector2(vector2_h0), .out_valid(out_valid_h0),
        .out_ready(out_ready), .busy(busy_h0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [0:N-1]  g;
        logic [V1-1:0] v1;
        logic [V2-1:0] v2;
    } exp_t;

    exp_t          q_main[$];
    int            q_h0[$];
    logic [V1-1:0] tv1 [N];
    logic [V2-1:0] tv2 [N];

    function automatic logic [0:N-1] oh(input int i);
        logic [0:N-1] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic expect_main(input int i);
        exp_t e;
        e.g  = oh(i);
        e.v1 = tv1[i];
        e.v2 = tv2[i];
        q_main.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input string tag);
        int k;
        k = 0;
        while (gnt == '0 && k < 20) begin
            tick(1);
            k++;
        end
        chk({tag, "_gnt_seen"}, 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 40) begin
            tick(1);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Main-instance monitor: every grant pops one expected transfer.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && gnt != '0) begin
            if (q_main.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                mon_e = q_main.pop_front();
                chk("gnt", 32'(gnt), 32'(mon_e.g));
                chk("vector1", 32'(vector1), 32'(mon_e.v1));
                chk("vector2", 32'(vector2), 32'(mon_e.v2));
                chk("valid_at_gnt", 32'(out_valid), 32'd1);
            end
        end
    end

    int cyc = 0;
    int last_h0 = 0;
    int h0_cnt = 0;
    int mon_i;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && gnt_h0 != '0) begin
            if (q_h0.size() == 0) begin
                chk("h0_gnt_unexpected", 32'(gnt_h0), 32'd0);
            end else begin
                mon_i = q_h0.pop_front();
                chk("h0_gnt", 32'(gnt_h0), 32'(oh(mon_i)));
                chk("h0_vector1", 32'(vector1_h0), 32'(tv1[mon_i]));
                chk("h0_vector2", 32'(vector2_h0), 32'(tv2[mon_i]));
                chk("h0_valid", 32'(out_valid_h0), 32'd1);
                if (h0_cnt > 0) chk("h0_gap", 32'(cyc - last_h0), 32'd2);
                last_h0 = cyc;
                h0_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tv1[0] = 2'b01; tv2[0] = 6'b000111;
        tv1[1] = 2'b10; tv2[1] = 6'b101100;
        tv1[2] = 2'b11; tv2[2] = 6'b100000;
        tv1[3] = 2'b01; tv2[3] = 6'b010011;
        for (int i = 0; i < N; i++) begin
            rv1[i*V1 +: V1] = tv1[i];
            rv2[i*V2 +: V2] = tv2[i];
        end
        req       = '0;
        req_h0    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        tick(2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_vector1", 32'(vector1), 32'd0);
        chk("rst_vector2", 32'(vector2), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single requester with three hold cycles.
        req = oh(1);
        expect_main(1);
        wait_gnt("t1");
        chk("t1_vector1_msb", 32'(vector1[0]), 32'd1);
        req = '0;
        tick(1);
        chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);
        chk("t1_busy_hold_a", 32'(busy), 32'd1);
        tick(2);
        chk("t1_busy_hold_c", 32'(busy), 32'd1);
        tick(1);
        chk("t1_idle_after_hold", 32'(busy), 32'd0);

        // Round-robin fairness with HOLD_CYCLES=0, all requests held.
        for (int i = 0; i < N; i++) q_h0.push_back(i);
        q_h0.push_back(0);
        req_h0 = '1;
        k = 0;
        while (h0_cnt < 5 && k < 40) begin
            tick(1);
            k++;
        end
        req_h0 = '0;
        chk("h0_grant_count", 32'(h0_cnt), 32'd5);
        tick(3);

        // Wrap and skip: grant 3, then {0,2} gives 0 then 2.
        req = oh(3);
        expect_main(3);
        wait_gnt("t3_r3");
        req = '0;
        wait_idle("t3_r3");
        req = oh(0) | oh(2);
        expect_main(0);
        expect_main(2);
        wait_gnt("t3_r0");
        req = oh(2);
        tick(1);
        wait_gnt("t3_r2");
        req = '0;
        wait_idle("t3_r2");

        // Backpressure: five cycles of out_ready low with another request pending.
        out_ready = 1'b0;
        req = oh(1);
        expect_main(1);
        wait_gnt("t4");
        req = oh(0);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("t4_valid_held", 32'(out_valid), 32'd1);
            chk("t4_vector1_held", 32'(vector1), 32'(tv1[1]));
            chk("t4_vector2_held", 32'(vector2), 32'(tv2[1]));
            chk("t4_no_gnt", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        tick(1);
        chk("t4_transfer_done", 32'(out_valid), 32'd0);
        expect_main(0);
        wait_gnt("t4_next");
        req = '0;
        wait_idle("t4");

        // Reset during DRIVE clears outputs at once and the pointer.
        out_ready = 1'b0;
        req = oh(1);
        expect_main(1);
        wait_gnt("t5");
        req = '0;
        tick(1);
        chk("t5_valid_before_rst", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_vector1", 32'(vector1), 32'd0);
        chk("t5_rst_vector2", 32'(vector2), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        tick(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req = oh(0) | oh(2);
        expect_main(0);
        wait_gnt("t5_ptr0");
        req = '0;
        wait_idle("t5_ptr0");
        req = oh(3);
        expect_main(3);
        wait_gnt("t5_r3");
        req = '0;
        wait_idle("t5_r3");

        // Bit order: vector2 MSB sits at index 0.
        req = oh(2);
        expect_main(2);
        wait_gnt("t6");
        chk("t6_vector2_idx0", 32'(vector2[0]), 32'd1);
        chk("t6_vector2_idx5", 32'(vector2[5]), 32'd0);
        req = '0;
        wait_idle("t6");

        tick(2);
        chk("q_main_drained", 32'(q_main.size()), 32'd0);
        chk("q_h0_drained", 32'(q_h0.size()), 32'd0);
        chk("h0_idle_end", 32'(busy_h0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_share_arbiter.md
Name: vec_share_arbiter

Overview:
- Round-robin arbiter that shares one downstream vector consumer (a 2-bit vector1 / 6-bit vector2 input pair plus clk) between NUM_REQ requesters.
- Captures the winning requester's vector pair into output registers and presents it with a valid/ready handshake.
- Holds the pair stable for a programmable settle time before re-arbitrating.
- Sits between the requesting control blocks and the consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- V1_W, 2, vector1 width
- V2_W, 6, vector2 width
- HOLD_CYCLES, 3, idle cycles after handshake before next arbitration (0..15)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  [0:NUM_REQ-1]  request, bit i = requester i
- req_vector1  input  [0:NUM_REQ*V1_W-1]  requester i occupies [i*V1_W : i*V1_W+V1_W-1]
- req_vector2  input  [0:NUM_REQ*V2_W-1]  requester i occupies [i*V2_W : i*V2_W+V2_W-1]
- gnt  output  [0:NUM_REQ-1]  one-hot, one-cycle grant pulse
- vector1  output  [0:V1_W-1]  registered granted vector1
- vector2  output  [0:V2_W-1]  registered granted vector2
- out_valid  output  1  vector pair offered to consumer
- out_ready  input  1  consumer accepts
- busy  output  1  high in any state except IDLE

Interface rule: all vectors use ascending ranges; index 0 is the MSB. Slicing must preserve the order, with no bit reversal anywhere.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, gnt=0, vector1=0, vector2=0, out_valid=0, busy=0.
  - Priority pointer ptr=0; hold counter=0.
- Reset mid-operation aborts immediately and discards the captured pair.

FSM states: IDLE, DRIVE, HOLD.
- IDLE, req!=0 at edge t:
  - Winner = first set req bit searching from ptr upward, wrapping at NUM_REQ.
  - At that edge: gnt<=onehot(winner); vector1/vector2<=winner slices; out_valid<=1; ptr<=(winner+1) mod NUM_REQ; state<=DRIVE.
  - gnt and out_valid are visible from cycle t+1.
- IDLE, req==0: stay in IDLE; outputs keep their last values; out_valid=0.
- DRIVE:
  - gnt<=0 after one cycle.
  - out_valid stays high and vectors stay stable until out_ready is sampled high.
  - On that edge: out_valid<=0, and
    - HOLD_CYCLES>0: state<=HOLD, cnt<=HOLD_CYCLES-1.
    - Otherwise: state<=IDLE.
  - out_ready already high on the first DRIVE cycle gives a one-cycle transfer.
- HOLD:
  - Vectors stay stable; out_valid=0; req is ignored.
  - cnt decrements each cycle; at cnt==0 go to state<=IDLE on the next edge.
  - Total HOLD_CYCLES cycles are spent in HOLD.
- Requester rules:
  - Keep req and its vectors stable until gnt.
  - Drop req the cycle after gnt to avoid back-to-back re-grant.
  - Otherwise the requester is re-eligible only after its round-robin turn.
- A req that drops before being granted is never granted.
- Grants are never issued while out_valid=1 or in HOLD, so at most one transfer is outstanding.
- Throughput: minimum 2+HOLD_CYCLES cycles per transfer with out_ready tied high.
- out_ready while out_valid=0 is ignored.
- Pointer wrap: winner NUM_REQ-1 sets ptr to 0.

Decomposition:
- Package vec_share_pkg holds:
  - state enum {IDLE, DRIVE, HOLD}
  - default V1_W/V2_W constants
  - function clog2 for ptr/cnt widths
- Sub-module vec_rr_pick: purely combinational.
  - Inputs: req, ptr.
  - Outputs: onehot winner, winner index, any.
  - Reusable for other shared resources.

Test Plan:
- Single requester: req=4'b0010, requester 1 vectors = 2'b10 / 6'b101100, out_ready=1.
  - Expected: gnt=4'b0010 one cycle later; vector1=2'b10 (vector1[0]=1); vector2=6'b101100; out_valid high one cycle; busy low after 3 hold cycles.
- Round-robin fairness: req=4'b1111 held continuously, HOLD_CYCLES=0.
  - Expected grant order 0,1,2,3,0.
- Wrap and skip: after a grant to requester 3, req=4'b0101.
  - Expected: requester 0 granted, then requester 2.
- Backpressure: out_ready=0 for 5 cycles after the grant.
  - Expected: out_valid and vectors stable for 5 cycles; no new gnt even with other req active; transfer completes on the cycle out_ready=1.
- Reset mid-DRIVE: assert rst_n=0 while out_valid=1.
  - Expected: outputs are 0 immediately (asynchronous); ptr=0; after release with req=4'b1000, requester 3 is granted.
- Bit order: requester 2 drives vector2=6'b100000.
  - Expected: vector2[0]=1 and vector2[5]=0 at the output.
